// File: rtl/bullet_hit_judge.sv
// bullet_hit_judge: per-pixel enemy/bullet overlap detector.
// A hit retires the bullet (one-cycle bullet_clear), waits for frame end,
// then holds boom high for BOOM_TICKS rising edges of clk_move, and finally
// waits for the enemy to be alive again before re-arming.
// Optional feature macro: BULLET_HIT_SCORE_EN builds the saturating 16-bit
// score counter; without it score is tied to zero.
module bullet_hit_judge #(
  parameter int BOOM_TICKS = 300,
  parameter int H_LAST     = 639,
  parameter int V_LAST     = 479
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_move,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        enemy_en,
  input  logic        bullet_en,
  input  logic        enemyplane_exist,
  output logic        boom,
  output logic        bullet_clear,
  output logic        hit_busy,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIT     = 2'd1,
    ST_BOOM    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [9:0] H_LAST_C    = 10'(H_LAST);
  localparam logic [9:0] V_LAST_C    = 10'(V_LAST);
  localparam logic [8:0] TICK_LAST_C = 9'(BOOM_TICKS - 1);

  state_t     state_reg, state_next;
  logic [8:0] tick_cnt_reg, tick_cnt_next;
  logic       move_q_reg;
  logic       boom_reg, bullet_clear_reg, hit_busy_reg;
  logic       bullet_clear_next;

  logic tick;
  logic hit_px;
  logic frame_end;

  assign tick      = clk_move & ~move_q_reg;
  assign hit_px    = enemy_en & bullet_en & enemyplane_exist;
  assign frame_end = (x == H_LAST_C) && (y == V_LAST_C);

  // Next-state logic: hit capture, frame-end wait, tick counting, re-arm wait
  always_comb begin
    state_next        = state_reg;
    tick_cnt_next     = tick_cnt_reg;
    bullet_clear_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hit_px) begin
          state_next        = ST_HIT;
          bullet_clear_next = 1'b1;
        end
      end
      ST_HIT: begin
        // Overlaps are ignored here; the explosion starts on a clean frame.
        if (frame_end) begin
          state_next    = ST_BOOM;
          tick_cnt_next = 9'd0;
        end
      end
      ST_BOOM: begin
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 9'd1;
          if (tick_cnt_reg == TICK_LAST_C) begin
            state_next = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // Hold off until the enemy judge has cleared its boom counter.
        if (enemyplane_exist) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, tick counter, edge detector and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      tick_cnt_reg     <= 9'd0;
      move_q_reg       <= 1'b0;
      boom_reg         <= 1'b0;
      bullet_clear_reg <= 1'b0;
      hit_busy_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tick_cnt_reg     <= tick_cnt_next;
      move_q_reg       <= clk_move;
      boom_reg         <= (state_next == ST_BOOM);
      bullet_clear_reg <= bullet_clear_next;
      hit_busy_reg     <= (state_next != ST_IDLE);
    end
  end

  assign boom         = boom_reg;
  assign bullet_clear = bullet_clear_reg;
  assign hit_busy     = hit_busy_reg;

`ifdef BULLET_HIT_SCORE_EN
  logic [15:0] score_reg, score_next;

  always_comb begin
    score_next = score_reg;
    if (bullet_clear_next && (score_reg != 16'hFFFF)) begin
      score_next = score_reg + 16'd1;
    end
  end

  // Saturating hit counter, advanced on the cycle a hit is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      score_reg <= 16'd0;
    end else begin
      score_reg <= score_next;
    end
  end

  assign score = score_reg;
`else
  assign score = 16'h0000;
`endif

endmodule
